// File: rtl/ysyx_24110015_ifu_fetch.sv
`default_nettype none
// ============================================================================
// ysyx_24110015_ifu_fetch : PC owner, one AXI-lite read per instruction,
//                           valid/ready hand-off to decode. Rev 1.0
// ============================================================================
module ysyx_24110015_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_upd_valid,
  input  logic [31:0] pc_next,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] pc_o,
  output logic [1:0]  fault,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    ST_AR   = 2'd0,
    ST_R    = 2'd1,
    ST_OUT  = 2'd2,
    ST_EXEC = 2'd3
  } state_t;

  localparam logic [1:0] FAULT_NONE   = 2'b00;
  localparam logic [1:0] FAULT_ACCESS = 2'b01;
  localparam logic [1:0] FAULT_ALIGN  = 2'b10;

  state_t      state;
  logic [31:0] pc;

  // Handshake outputs depend on the state register only.
  assign arvalid   = (state == ST_AR);
  assign rready    = (state == ST_R);
  assign out_valid = (state == ST_OUT);
  assign araddr    = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_AR;
      pc        <= RESET_PC;
      pc_o      <= RESET_PC;
      inst      <= 32'h0;
      fault     <= FAULT_NONE;
      fetch_cnt <= 32'h0;
    end else begin
      case (state)
        ST_AR: begin
          if (arready) begin
            pc_o  <= pc;
            state <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            inst  <= rdata;
            fault <= (rresp != 2'b00) ? FAULT_ACCESS : FAULT_NONE;
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (pc_upd_valid) begin
            pc <= pc_next;
            if (pc_next[1:0] != 2'b00) begin
              // Misaligned target: report it to decode without touching the bus.
              pc_o  <= pc_next;
              inst  <= 32'h0;
              fault <= FAULT_ALIGN;
              state <= ST_OUT;
            end else begin
              state <= ST_AR;
            end
          end
        end
        default: state <= ST_AR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110015_ifu_fetch.sv
`default_nettype none
// Directed self-checking bench for ysyx_24110015_ifu_fetch.
module tb_ysyx_24110015_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_upd_valid;
  logic [31:0] pc_next;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc_o;
  logic [1:0]  fault;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fetch_cnt;

  int tests  = 0;
  int failed = 0;

  ysyx_24110015_ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .pc_upd_valid(pc_upd_valid), .pc_next(pc_next),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .pc_o(pc_o), .fault(fault),
    .out_valid(out_valid), .out_ready(out_ready), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; pc_upd_valid = 1'b0; pc_next = 32'h0;
    arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0; out_ready = 1'b0;

    // Reset state
    step();
    check("rst_arvalid",   32'(arvalid),   32'd1);
    check("rst_araddr",    araddr,         32'h8000_0000);
    check("rst_rready",    32'(rready),    32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_inst",      inst,           32'h0);
    check("rst_fault",     32'(fault),     32'd0);
    check("rst_pc_o",      pc_o,           32'h8000_0000);
    check("rst_cnt",       fetch_cnt,      32'd0);

    // 1: best-case fetch
    rst = 1'b1; arready = 1'b1;
    step();
    check("t1_rready",  32'(rready),  32'd1);
    check("t1_arvalid", 32'(arvalid), 32'd0);
    check("t1_pc_o",    pc_o,         32'h8000_0000);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0010_0093; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_inst",      inst,           32'h0010_0093);
    check("t1_fault",     32'(fault),     32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_cnt",        fetch_cnt,      32'd1);
    check("t1_exec_valid", 32'(out_valid), 32'd0);
    check("t1_exec_ar",    32'(arvalid),   32'd0);
    pc_upd_valid = 1'b1; pc_next = 32'h8000_0004;
    step();
    pc_upd_valid = 1'b0;
    check("t1_next_arvalid", 32'(arvalid), 32'd1);
    check("t1_next_araddr",  araddr,       32'h8000_0004);

    // 2: arready stall, with stray pc_upd_valid ignored in AR
    pc_upd_valid = 1'b1; pc_next = 32'h8000_0100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_arvalid", 32'(arvalid), 32'd1);
      check("t2_araddr",  araddr,       32'h8000_0004);
      check("t2_rready",  32'(rready),  32'd0);
    end
    pc_upd_valid = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    check("t2_rready_hs", 32'(rready), 32'd1);
    check("t2_pc_o",      pc_o,        32'h8000_0004);

    // 3: decode backpressure
    rvalid = 1'b1; rdata = 32'h0020_8113;
    step();
    rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_out_valid", 32'(out_valid), 32'd1);
      check("t3_inst",      inst,           32'h0020_8113);
      check("t3_pc_o",      pc_o,           32'h8000_0004);
      check("t3_cnt_hold",  fetch_cnt,      32'd1);
    end
    out_ready = 1'b1;
    step();
    check("t3_cnt", fetch_cnt, 32'd2);
    rvalid = 1'b1; // out_ready and rvalid ignored in EXEC
    step();
    out_ready = 1'b0; rvalid = 1'b0;
    check("t3_cnt_exec",  fetch_cnt, 32'd2);
    check("t3_inst_exec", inst,      32'h0020_8113);

    // 4: error response then normal fetch
    pc_upd_valid = 1'b1; pc_next = 32'h8000_0008;
    step();
    pc_upd_valid = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
    step();
    rvalid = 1'b0; rresp = 2'b00;
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_inst",  inst,       32'h1234_5678);
    check("t4_pc_o",  pc_o,       32'h8000_0008);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; pc_upd_valid = 1'b1; pc_next = 32'h8000_0004;
    step();
    pc_upd_valid = 1'b0;
    check("t4_araddr", araddr, 32'h8000_0004);
    arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013;
    step();
    rvalid = 1'b0;
    check("t4_fault_ok", 32'(fault), 32'd0);
    check("t4_inst_ok",  inst,       32'h0000_0013);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_cnt", fetch_cnt, 32'd4);

    // 5: misaligned redirect
    pc_upd_valid = 1'b1; pc_next = 32'h8000_0006;
    step();
    pc_upd_valid = 1'b0;
    check("t5_arvalid",   32'(arvalid),   32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd1);
    check("t5_fault",     32'(fault),     32'd2);
    check("t5_pc_o",      pc_o,           32'h8000_0006);
    check("t5_inst",      inst,           32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5_cnt", fetch_cnt, 32'd5);

    // 6: asynchronous reset while in R, then a late rvalid
    pc_upd_valid = 1'b1; pc_next = 32'h8000_0010;
    step();
    pc_upd_valid = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    check("t6_in_r", 32'(rready), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_arvalid", 32'(arvalid), 32'd1);
    check("t6_araddr",  araddr,       32'h8000_0000);
    check("t6_rready",  32'(rready),  32'd0);
    check("t6_cnt",     fetch_cnt,    32'd0);
    #2;
    rst = 1'b1;
    step();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    rvalid = 1'b0;
    check("t6_late_arvalid", 32'(arvalid),   32'd1);
    check("t6_late_rready",  32'(rready),    32'd0);
    check("t6_late_valid",   32'(out_valid), 32'd0);
    check("t6_late_inst",    inst,           32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_24110015_ifu_fetch.md
# ysyx_24110015_ifu_fetch

Instruction fetch unit for the single-issue multi-cycle core. It owns the architectural PC and issues one read per instruction on an AXI-lite-style read channel. It hands the returned word and its PC to the decode stage over a valid/ready handshake, then waits for the write-back stage to return the next PC before starting the next fetch. It is the producer side of the decode stage's `inst`/`pc_i` input.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- pc_upd_valid  input  1  write-back supplies the next PC (one-cycle pulse).
- pc_next  input  32  next PC from write-back.
- araddr  output  32  read address.
- arvalid  output  1  read-address valid.
- arready  input  1  read-address accepted.
- rdata  input  32  read data.
- rresp  input  2  read response; 2'b00 = OKAY, anything else = error.
- rvalid  input  1  read data valid.
- rready  output  1  ready for read data.
- inst  output  32  fetched instruction (registered).
- pc_o  output  32  PC of `inst` (registered).
- fault  output  2  00 = none, 01 = access fault, 10 = misaligned fetch.
- out_valid  output  1  `inst`, `pc_o` and `fault` are valid for decode.
- out_ready  input  1  decode accepts the instruction.
- fetch_cnt  output  32  number of instructions handed to decode.

## Operation
The FSM has four states: AR, R, OUT, EXEC. Reset enters AR.

- **AR**
  - arvalid=1, araddr=pc.
  - On arvalid&arready, go to R.
  - araddr must stay stable while arvalid=1 and arready=0.
- **R**
  - rready=1.
  - On rvalid, latch inst=rdata and fault=(rresp!=0)?01:00, then go to OUT.
- **OUT**
  - out_valid=1.
  - On out_ready: fetch_cnt+=1 (wraps 32'hFFFF_FFFF to 0), then go to EXEC.
  - inst, pc_o and fault must not change while in OUT.
- **EXEC**
  - All handshake outputs are 0; the block waits for pc_upd_valid.
  - On pc_upd_valid with pc_next[1:0]==0: pc=pc_next, go to AR.
  - On pc_upd_valid with pc_next[1:0]!=0:
    - pc=pc_next, pc_o=pc_next, inst=32'h0, fault=10.
    - Go directly to OUT with no bus access.
- **Signals ignored outside their state**
  - pc_upd_valid is ignored outside EXEC.
  - rvalid outside R is ignored (protocol violation; no state change).
  - out_ready outside OUT is ignored.
- **pc_o**
  - Loaded from pc at the AR→R transition.
  - pc_o always equals the address that produced `inst`.
- **Moore outputs**: arvalid, rready and out_valid are decoded from the state register only, with no combinational path from any input.

Reset values:
- State AR, pc=RESET_PC, pc_o=RESET_PC.
- inst=0, fault=00, fetch_cnt=0.
- Hence arvalid=1 and araddr=RESET_PC immediately while/after reset is released; rready=0, out_valid=0.

## Timing
- Best case, with arready=1 in AR and rvalid in the first R cycle:
  - AR in cycle n, R in n+1, OUT in n+2 with out_valid=1.
  - With out_ready=1, EXEC in n+3.
  - With pc_upd_valid in n+3, the next AR is in n+4.
  - Minimum 4 cycles per instruction.
- Each wait on arready, rvalid, out_ready or pc_upd_valid stretches its state by exactly the stall length; there is no timeout.
- Misaligned redirect: EXEC→OUT in one cycle; out_valid appears the cycle after pc_upd_valid.
- Reset asserted mid-transaction: immediate return to the reset values regardless of state. The outstanding bus transaction is abandoned, and a late rvalid after reset is ignored (AR state).
- A simultaneous rvalid and out_ready cannot interact: the two are consumed in distinct states.

## Test plan
1. Release reset with arready=1 and rvalid one cycle later with rdata=32'h00100093, rresp=00:
   - Required: araddr=32'h8000_0000 on the first cycle.
   - Required: out_valid in cycle 2 with inst=32'h00100093, pc_o=32'h8000_0000, fault=00.
2. Hold arready=0 for 3 cycles:
   - Required: arvalid stays 1 and araddr stays constant for all 4 cycles.
   - Required: rready=0 until the handshake completes.
3. Backpressure: hold out_ready=0 for 5 cycles in OUT.
   - Required: out_valid, inst and pc_o stay stable.
   - Required: fetch_cnt increments only once, on acceptance.
4. Error response rresp=2'b10:
   - Required: fault=01 delivered with inst=rdata.
   - Required: the next fetch proceeds normally after pc_upd_valid with pc_next=32'h8000_0004.
5. pc_upd_valid with pc_next=32'h8000_0006:
   - Required: no arvalid.
   - Required: out_valid on the next cycle with fault=10, pc_o=32'h8000_0006, inst=0.
6. Assert rst in R state, then release:
   - Required: the state returns to AR with araddr=RESET_PC and fetch_cnt=0.
   - Required: an rvalid pulse 1 cycle after release is ignored.
